// File: rtl/axis_gmii_rx_ctrl_pkg.sv
// Shared definitions for the GMII/MII receive sequencing controller:
// speed encodings, controller state type and speed normalisation.
package axis_gmii_rx_ctrl_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    IDLE     = 2'd1,
    FRAME    = 2'd2,
    QUIESCE  = 2'd3
  } state_t;

  // The reserved encoding 2'b11 runs the line at gigabit rate.
  function automatic logic [1:0] norm_speed(input logic [1:0] s);
    return (s == 2'b11) ? SPEED_1000 : s;
  endfunction

endpackage

// File: rtl/gmii_clk_en_gen.sv
// Receiver clock-enable divider: every cycle at 1000M, one pulse per DIV cycles
// at 100M/10M. clr_i restarts the count so the first pulse lands DIV cycles later.
module gmii_clk_en_gen
  import axis_gmii_rx_ctrl_pkg::*;
#(
  parameter int DIV_100 = 5,
  parameter int DIV_10  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed_i,
  input  logic       clr_i,
  output logic       clk_enable_o
);

  localparam int DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
  localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] last_cnt;
  logic          is_gig;
  logic          run_q;

  assign is_gig   = speed_i[1];
  assign last_cnt = (speed_i == SPEED_10) ? CW'(DIV_10 - 1) : CW'(DIV_100 - 1);

  // run_q keeps the gigabit enable low while reset is applied.
  assign clk_enable_o = is_gig ? run_q : (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || is_gig || (cnt_q == last_cnt)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_gmii_rx_ctrl.sv
// GMII/MII receive sequencing controller: frame-boundary reconfiguration after a
// quiet line period. Optional statistics counters under AXIS_GMII_RX_CTRL_STATS_EN.
module axis_gmii_rx_ctrl
  import axis_gmii_rx_ctrl_pkg::*;
#(
  parameter int CLK_DIV_100  = 5,
  parameter int CLK_DIV_10   = 50,
  parameter int QUIET_CYCLES = 16,
  parameter int STAT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cfg_speed,
  input  logic                  cfg_rx_enable_req,
  input  logic                  gmii_rx_dv,
  input  logic                  rx_start_packet,
  input  logic                  rx_tvalid,
  input  logic                  rx_tlast,
  input  logic                  rx_error_bad_frame,
  input  logic                  rx_error_bad_fcs,
  input  logic                  stat_clear,
  output logic                  clk_enable,
  output logic                  mii_select,
  output logic                  cfg_rx_enable,
  output logic [1:0]            speed_active,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] stat_frames,
  output logic [STAT_WIDTH-1:0] stat_bad_frame,
  output logic [STAT_WIDTH-1:0] stat_bad_fcs
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);

  state_t        state_q, state_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [1:0]    speed_q, speed_d;
  logic          mii_q,   mii_d;

  logic [1:0]    speed_req;
  logic          chg;
  logic          eof;
  logic          quiet_done;
  logic          speed_change;

  gmii_clk_en_gen #(
    .DIV_100 (CLK_DIV_100),
    .DIV_10  (CLK_DIV_10)
  ) u_clk_en (
    .clk          (clk),
    .rst_n        (rst_n),
    .speed_i      (speed_q),
    .clr_i        (speed_change),
    .clk_enable_o (clk_enable)
  );

  assign speed_req  = norm_speed(cfg_speed);
  assign chg        = !cfg_rx_enable_req || (speed_req != speed_q);
  assign eof        = rx_tvalid & rx_tlast;
  assign quiet_done = (state_q == QUIESCE) && clk_enable && !gmii_rx_dv &&
                      (quiet_q == QW'(QUIET_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    quiet_d = '0;
    speed_d = speed_q;
    case (state_q)
      DISABLED: begin
        if (cfg_rx_enable_req) state_d = QUIESCE;
      end
      IDLE: begin
        // A start in the same cycle as a change request wins; chg stays pending.
        if (rx_start_packet) state_d = FRAME;
        else if (chg)        state_d = QUIESCE;
      end
      FRAME: begin
        if (eof) state_d = chg ? QUIESCE : IDLE;
      end
      QUIESCE: begin
        quiet_d = quiet_q;
        if (gmii_rx_dv) begin
          quiet_d = '0;
        end else if (quiet_done) begin
          quiet_d = '0;
          speed_d = speed_req;
          state_d = cfg_rx_enable_req ? IDLE : DISABLED;
        end else if (clk_enable) begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      default: state_d = DISABLED;
    endcase
  end

  assign mii_d        = (speed_d != SPEED_1000);
  assign speed_change = (speed_d != speed_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISABLED;
      quiet_q <= '0;
      speed_q <= SPEED_1000;
      mii_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      speed_q <= speed_d;
      mii_q   <= mii_d;
    end
  end

  assign mii_select    = mii_q;
  assign speed_active  = speed_q;
  assign cfg_rx_enable = (state_q == IDLE) || (state_q == FRAME);
  assign busy          = (state_q == FRAME) || (state_q == QUIESCE);

`ifdef AXIS_GMII_RX_CTRL_STATS_EN
  logic [2:0] stat_inc;
  assign stat_inc = {rx_error_bad_fcs, rx_error_bad_frame, eof};

  // Saturating counters; clear beats a same-cycle increment.
  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [STAT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (stat_clear) begin
        cnt_q <= '0;
      end else if (stat_inc[gi] && (cnt_q != {STAT_WIDTH{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stat_frames    = g_stat[0].cnt_q;
  assign stat_bad_frame = g_stat[1].cnt_q;
  assign stat_bad_fcs   = g_stat[2].cnt_q;
`else
  logic unused_stat_in;
  assign unused_stat_in = ^{stat_clear, rx_error_bad_frame, rx_error_bad_fcs};
  assign stat_frames    = '0;
  assign stat_bad_frame = '0;
  assign stat_bad_fcs   = '0;
`endif

endmodule

// File: tb/tb_axis_gmii_rx_ctrl.sv
// Scoreboard bench for axis_gmii_rx_ctrl: a behavioural model predicts each
// cycle's outputs into a queue; a monitor pops and compares.
module tb_axis_gmii_rx_ctrl;

  localparam int SW = 4;
  localparam int QUIET = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    cfg_speed = 2'b10;
  logic          cfg_rx_enable_req = 1'b0;
  logic          gmii_rx_dv = 1'b0;
  logic          rx_start_packet = 1'b0;
  logic          rx_tvalid = 1'b0;
  logic          rx_tlast = 1'b0;
  logic          rx_error_bad_frame = 1'b0;
  logic          rx_error_bad_fcs = 1'b0;
  logic          stat_clear = 1'b0;
  logic          clk_enable, mii_select, cfg_rx_enable, busy;
  logic [1:0]    speed_active;
  logic [SW-1:0] stat_frames, stat_bad_frame, stat_bad_fcs;

  axis_gmii_rx_ctrl #(
    .CLK_DIV_100 (5), .CLK_DIV_10 (50), .QUIET_CYCLES (QUIET), .STAT_WIDTH (SW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .cfg_speed (cfg_speed),
    .cfg_rx_enable_req (cfg_rx_enable_req), .gmii_rx_dv (gmii_rx_dv),
    .rx_start_packet (rx_start_packet), .rx_tvalid (rx_tvalid), .rx_tlast (rx_tlast),
    .rx_error_bad_frame (rx_error_bad_frame), .rx_error_bad_fcs (rx_error_bad_fcs),
    .stat_clear (stat_clear), .clk_enable (clk_enable), .mii_select (mii_select),
    .cfg_rx_enable (cfg_rx_enable), .speed_active (speed_active), .busy (busy),
    .stat_frames (stat_frames), .stat_bad_frame (stat_bad_frame), .stat_bad_fcs (stat_bad_fcs)
  );

  always #4 clk = ~clk;

  typedef struct {
    bit          ce, mii, en, busy;
    bit [1:0]    spd;
    bit [SW-1:0] fr, bfr, bfc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: receiver on/in-frame/quiescing flags, cycles since the
  // last speed change for the enable cadence, plain integer statistics.
  int m_speed, m_phase, m_quiet;
  bit m_live, m_on, m_frame, m_quies;
  int m_stat[3];
  int stat_max = (1 << SW) - 1;

  function automatic void model_reset();
    m_speed = 2; m_phase = 0; m_quiet = 0; m_live = 0;
    m_on = 0; m_frame = 0; m_quies = 0;
    for (int i = 0; i < 3; i++) m_stat[i] = 0;
  endfunction

  function automatic bit model_ce();
    int div;
    div = (m_speed == 0) ? 50 : 5;
    if (m_speed == 2) return m_live;
    return (m_phase % div) == (div - 1);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.ce = model_ce();
    e.mii = (m_speed != 2);
    e.en = m_on;
    e.busy = m_frame || m_quies;
    e.spd = 2'(m_speed);
`ifdef AXIS_GMII_RX_CTRL_STATS_EN
    e.fr = SW'(m_stat[0]); e.bfr = SW'(m_stat[1]); e.bfc = SW'(m_stat[2]);
`else
    e.fr = '0; e.bfr = '0; e.bfc = '0;
`endif
    return e;
  endfunction

  function automatic void model_step();
    int  want;
    int  new_speed;
    bit  ce, chg, eof;
    bit  inc[3];
    if (!rst_n) begin
      model_reset();
      return;
    end
    want = (cfg_speed == 2'b11) ? 2 : int'(cfg_speed);
    ce = model_ce();
    chg = !cfg_rx_enable_req || (want != m_speed);
    eof = rx_tvalid && rx_tlast;
    new_speed = m_speed;
    if (m_quies) begin
      if (gmii_rx_dv) m_quiet = 0;
      else if (ce) begin
        m_quiet++;
        if (m_quiet == QUIET) begin
          m_quiet = 0; new_speed = want; m_quies = 0; m_on = cfg_rx_enable_req;
        end
      end
    end else if (m_frame) begin
      if (eof) begin
        m_frame = 0;
        if (chg) begin m_on = 0; m_quies = 1; end
      end
    end else if (m_on) begin
      if (rx_start_packet) m_frame = 1;
      else if (chg) begin m_on = 0; m_quies = 1; end
    end else if (cfg_rx_enable_req) begin
      m_quies = 1;
    end
    inc[0] = eof; inc[1] = rx_error_bad_frame; inc[2] = rx_error_bad_fcs;
    for (int i = 0; i < 3; i++) begin
      if (stat_clear) m_stat[i] = 0;
      else if (inc[i] && m_stat[i] < stat_max) m_stat[i]++;
    end
    if (new_speed != m_speed) m_phase = 0;
    else m_phase++;
    m_speed = new_speed;
    m_live = 1;
  endfunction

  // Level signals held across cycles; pulses are per-call arguments.
  bit       lv_rst = 0, lv_req = 0, lv_dv = 0;
  bit [1:0] lv_spd = 2'b10;

  task automatic drive(input bit sp, input bit tv, input bit tl,
                       input bit ef, input bit ec, input bit cl);
    @(negedge clk);
    rst_n = lv_rst; cfg_rx_enable_req = lv_req; cfg_speed = lv_spd; gmii_rx_dv = lv_dv;
    rx_start_packet = sp; rx_tvalid = tv; rx_tlast = tl;
    rx_error_bad_frame = ef; rx_error_bad_fcs = ec; stat_clear = cl;
    if (!rst_n) model_reset();
    exp_q.push_back(model_out());
    model_step();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic frame(input int len);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i < len; i++) drive(0, 1, i == len - 1, 0, 0, 0);
    $display("frame len=%0d speed_req=%0d speed_active=%0d", len, lv_spd, speed_active);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (clk_enable !== e.ce || mii_select !== e.mii || cfg_rx_enable !== e.en ||
            busy !== e.busy || speed_active !== e.spd || stat_frames !== e.fr ||
            stat_bad_frame !== e.bfr || stat_bad_fcs !== e.bfc) begin
          bad++;
          $display("FAIL outputs t=%0t got ce=%b mii=%b en=%b busy=%b spd=%b fr=%0d bfr=%0d bfc=%0d want ce=%b mii=%b en=%b busy=%b spd=%b fr=%0d bfr=%0d bfc=%0d",
                   $time, clk_enable, mii_select, cfg_rx_enable, busy, speed_active,
                   stat_frames, stat_bad_frame, stat_bad_fcs, e.ce, e.mii, e.en, e.busy,
                   e.spd, e.fr, e.bfr, e.bfc);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    bad++;
    $display("FAIL watchdog time limit reached got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    model_reset();
    lv_rst = 0; hold(3);
    // Bring up at 10M: quiet period at gigabit rate, then 50-cycle cadence.
    lv_rst = 1; lv_req = 1; lv_spd = 2'b00; lv_dv = 0;
    hold(1000);
    // Move to 1000M and pass a 64-byte frame.
    lv_spd = 2'b10; hold(900);
    frame(64); hold(10);
    // Speed change mid-frame, then a dv glitch restarts the quiet count.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) drive(0, 1, 0, 0, 0, 0);
    lv_spd = 2'b01;
    for (int i = 0; i < 34; i++) drive(0, 1, i == 33, 0, 0, 0);
    hold(5); lv_dv = 1; hold(1); lv_dv = 0; hold(40);
    // Start and disable request in the same idle cycle.
    lv_req = 0; frame(20); hold(200);
    // Statistics near saturation and clear priority.
    lv_req = 1; hold(100);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, i[0], 1, 0);
    drive(0, 0, 0, 1, 1, 1);
    hold(2);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
    // Reset in the middle of a frame, then a clean restart.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0, 0);
    lv_rst = 0; drive(0, 1, 0, 0, 0, 0); drive(0, 1, 1, 0, 0, 0);
    lv_rst = 1; hold(120);
    frame(16); hold(5);
    // Randomised traffic and reconfiguration.
    lv_spd = 2'b11; hold(60);
    for (int i = 0; i < 4000; i++) begin
      bit tv, tl;
      lv_rst = ($urandom_range(399) != 0);
      if ($urandom_range(299) == 0) lv_req = ~lv_req;
      if ($urandom_range(249) == 0) lv_spd = 2'($urandom_range(3));
      if ($urandom_range(9) == 0) lv_dv = ~lv_dv;
      tv = $urandom_range(1) == 1;
      tl = tv && ($urandom_range(19) == 0);
      drive($urandom_range(29) == 0, tv, tl, $urandom_range(14) == 0,
            $urandom_range(14) == 0, $urandom_range(99) == 0);
    end
    lv_rst = 1; hold(5);
    repeat (3) @(negedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
